hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/hazard_unit_mem_wait_fsm.sv | 72 +++++++
 rtl/hazard_unit.sv | 111 +++++++++++
 tb/tb_hazard_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit.
// Forward selects, memory-wait FSM states and default timeout.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ERR  = 2'b10
  } mstate_e;

  localparam int TIMEOUT_DEF = 255;

  // MEM result is younger than WB, so it wins.
  function automatic fwd_e fwd_sel(
    input logic [4:0] src,
    input logic [4:0] wreg_m,
    input logic       rw_m,
    input logic [4:0] wreg_w,
    input logic       rw_w
  );
    fwd_e sel;
    sel = FWD_RF;
    if (src != 5'd0 && src == wreg_m && rw_m)
      sel = FWD_MEM;
    else if (src != 5'd0 && src == wreg_w && rw_w)
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_mem_wait_fsm.sv
// Data-memory wait-state tracker with timeout.
// ERR is sticky and left only through reset.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic memreq,
  input  logic dmem_ready,
  output logic memstall,
  output logic bus_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  mstate_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    memstall  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (memreq && !dmem_ready) begin
          memstall = 1'b1;
          state_d  = S_WAIT;
          cnt_d    = CW'(1);
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          memstall = 1'b1;
          if (cnt_q == CW'(TIMEOUT)) begin
            state_d   = S_ERR;
            bus_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_ERR: begin
        memstall = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use stall,
// branch flush and memory wait-state stall priority.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  writeregE,
  input  logic [4:0]  writeregM,
  input  logic [4:0]  writeregW,
  input  logic        regwriteE,
  input  logic        regwriteM,
  input  logic        regwriteW,
  input  logic        memtoregE,
  input  logic        memwriteM,
  input  logic        memtoregM,
  input  logic        pcsrcM,
  input  logic        dmem_ready,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        flushD,
  output logic        flushE,
  output logic        flushW,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        bus_err,
  output logic [31:0] stall_cnt
);

  logic memreq;
  logic memstall;
  logic lwstall;
  logic any_stall;

  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign memreq = memwriteM | memtoregM;

  mem_wait_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .memreq     (memreq),
    .dmem_ready (dmem_ready),
    .memstall   (memstall),
    .bus_err    (bus_err)
  );

  assign forwardAE = fwd_sel(rsE, writeregM, regwriteM,
                             writeregW, regwriteW);
  assign forwardBE = fwd_sel(rtE, writeregM, regwriteM,
                             writeregW, regwriteW);

  assign lwstall = memtoregE & regwriteE
                 & (writeregE != 5'd0)
                 & ((writeregE == rsD) | (writeregE == rtD));

  // Memory stall freezes everything; a taken branch beats load-use.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (!rst) begin
      if (memstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (pcsrcM) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (lwstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  assign any_stall = stallF | stallD | stallE | stallM;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (any_stall && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= 32'd0;
    else
      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized checks of hazard_unit
// against a cycle-level reference model.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rsD = '0, rtD = '0, rsE = '0, rtE = '0;
  logic [4:0]  writeregE = '0, writeregM = '0, writeregW = '0;
  logic        regwriteE = 0, regwriteM = 0, regwriteW = 0;
  logic        memtoregE = 0, memwriteM = 0, memtoregM = 0;
  logic        pcsrcM = 0, dmem_ready = 1;
  logic        stallF, stallD, stallE, stallM;
  logic        flushD, flushE, flushW, bus_err;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] stall_cnt;

  hazard_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM),
    .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .memtoregE(memtoregE),
    .memwriteM(memwriteM), .memtoregM(memtoregM),
    .pcsrcM(pcsrcM), .dmem_ready(dmem_ready),
    .stallF(stallF), .stallD(stallD),
    .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .bus_err(bus_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: stalled cycles of the current access, error flag, counter.
  int          m_waited = 0;
  bit          m_err = 0;
  longint      m_cnt = 0;
  bit          m_any = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] s);
    if (s != 0 && regwriteM && s == writeregM) return 2'd2;
    if (s != 0 && regwriteW && s == writeregW) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_check();
    bit lw, ms, mr;
    bit eF, eD, eE, eM, fD, fE, fW;
    mr = memwriteM || memtoregM;
    lw = memtoregE && regwriteE && writeregE != 0
         && (writeregE == rsD || writeregE == rtD);
    if (m_err) ms = 1;
    else if (m_waited > 0) ms = !dmem_ready;
    else ms = mr && !dmem_ready;
    {eF, eD, eE, eM, fD, fE, fW} = '0;
    if (!rst) begin
      eE = ms; eM = ms; fW = ms;
      eF = ms || (lw && !pcsrcM);
      eD = eF;
      fD = !ms && pcsrcM;
      fE = !ms && (pcsrcM || lw);
    end
    m_any = eF || eD || eE || eM;
    chk("stallF", 32'(stallF), 32'(eF));
    chk("stallD", 32'(stallD), 32'(eD));
    chk("stallE", 32'(stallE), 32'(eE));
    chk("stallM", 32'(stallM), 32'(eM));
    chk("flushD", 32'(flushD), 32'(fD));
    chk("flushE", 32'(flushE), 32'(fE));
    chk("flushW", 32'(flushW), 32'(fW));
    chk("fwdA", 32'(forwardAE), 32'(ref_fwd(rsE)));
    chk("fwdB", 32'(forwardBE), 32'(ref_fwd(rtE)));
    chk("bus_err", 32'(bus_err), 32'(m_err));
    chk("stall_cnt", stall_cnt, 32'(m_cnt));
  endtask

  task automatic model_step();
    bit ms;
    ms = !rst && (stallE === 1'b1 || m_err) ? 1'b1 : 1'b0;
    ms = m_err || (m_waited > 0 ? !dmem_ready
                   : ((memwriteM || memtoregM) && !dmem_ready));
    if (rst) begin
      m_waited = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (m_any && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (!m_err) begin
        if (ms) begin
          m_waited++;
          if (m_waited == TO + 1) begin
            m_err = 1; m_waited = 0;
          end
        end else begin
          m_waited = 0;
        end
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_in();
    {rsD, rtD, rsE, rtE} = '0;
    {writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE} = '0;
    {memwriteM, memtoregM, pcsrcM} = '0;
    dmem_ready = 1;
  endtask

  logic [31:0] c0;

  initial begin
    clear_in();
    rst = 1;
    half(); chk("rst_stallF", 32'(stallF), 0); tick();
    half(); tick();
    rst = 0;
    half();
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_berr", 32'(bus_err), 0);
    tick();

    // forwarding
    rsE = 5; writeregM = 5; regwriteM = 1;
    writeregW = 5; regwriteW = 1; rtE = 5;
    half(); chk("fwdA_mem", 32'(forwardAE), 2);
    chk("fwdB_mem", 32'(forwardBE), 2); tick();
    regwriteM = 0;
    half(); chk("fwdA_wb", 32'(forwardAE), 1); tick();
    rsE = 0;
    half(); chk("fwdA_zero", 32'(forwardAE), 0); tick();

    // load-use
    clear_in();
    memtoregE = 1; regwriteE = 1; writeregE = 8; rtD = 8;
    half(); c0 = stall_cnt;
    chk("lw_stallF", 32'(stallF), 1);
    chk("lw_stallD", 32'(stallD), 1);
    chk("lw_flushE", 32'(flushE), 1);
    chk("lw_stallE", 32'(stallE), 0);
    tick();
    clear_in();
    half(); chk("lw_cnt", stall_cnt, c0 + 1);
    chk("lw_once", 32'(stallF), 0); tick();

    // branch beats load-use
    memtoregE = 1; regwriteE = 1; writeregE = 8; rtD = 8; pcsrcM = 1;
    half(); c0 = stall_cnt;
    chk("pr_flushD", 32'(flushD), 1);
    chk("pr_flushE", 32'(flushE), 1);
    chk("pr_stallF", 32'(stallF), 0);
    chk("pr_stallD", 32'(stallD), 0);
    tick();
    clear_in();
    half(); chk("pr_cnt", stall_cnt, c0); tick();

    // memory wait of 3 cycles
    memtoregM = 1; dmem_ready = 0;
    half(); c0 = stall_cnt;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) half();
      chk("mw_stallM", 32'(stallM), 1);
      chk("mw_flushW", 32'(flushW), 1);
      tick();
    end
    dmem_ready = 1;
    half(); chk("mw_release", 32'(stallF), 0); tick();
    clear_in();
    half();
    chk("mw_idle", 32'(dut.u_fsm.state_q), 32'(S_IDLE));
    chk("mw_cnt", stall_cnt, c0 + 3);
    tick();

    // timeout
    memtoregM = 1; dmem_ready = 0;
    for (int i = 0; i < TO + 1; i++) begin
      half(); chk("to_stall", 32'(stallE), 1); tick();
    end
    memtoregM = 0; dmem_ready = 1;
    half();
    chk("to_err", 32'(dut.u_fsm.state_q), 32'(S_ERR));
    chk("to_berr", 32'(bus_err), 1);
    chk("to_hold", 32'(stallF & stallD & stallE & stallM & flushW), 1);
    tick();
    rst = 1;
    half(); chk("to_rst_out", 32'(stallF), 0); tick();
    rst = 0;
    half();
    chk("to_rst_berr", 32'(bus_err), 0);
    chk("to_rst_cnt", stall_cnt, 0);
    chk("to_rst_idle", 32'(dut.u_fsm.state_q), 32'(S_IDLE));
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      rsD = 5'($urandom_range(0, 3));
      rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3));
      rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom);
      regwriteM = 1'($urandom);
      regwriteW = 1'($urandom);
      memtoregE = 1'($urandom);
      memwriteM = ($urandom_range(0, 3) == 0);
      memtoregM = ($urandom_range(0, 3) == 0);
      pcsrcM = ($urandom_range(0, 4) == 0);
      dmem_ready = ($urandom_range(0, 9) < 6);
      half();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
